// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared register-file geometry and write-back source encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'h0;

  typedef enum logic [1:0] {
    WB_ALU    = 2'd0,
    WB_LOAD   = 2'd1,
    WB_MULDIV = 2'd2
  } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter_if
// Description : Packed valid/ready write-back request bundle for all requesters.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = regfile_pkg::ADDR_W,
  parameter int DATA_W  = regfile_pkg::DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_reg;
  logic [NUM_REQ*DATA_W-1:0] req_data;

  modport master (
    output req_valid,
    output req_reg,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_reg,
    input  req_data,
    output req_ready
  );

endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin one-hot arbiter; owns the rotating priority pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  wire                clock,
  input  wire                reset_n,
  input  wire  [NUM_REQ-1:0] req,
  input  wire                advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [c_PTR_W-1:0] r_ptr;
  logic [c_PTR_W-1:0] w_winner;
  logic [c_PTR_W-1:0] w_ptr_nxt;
  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_masked;
  logic [NUM_REQ-1:0] w_pick_src;

  // Search from ptr upward first; fall back to the full vector for the wrap.
  assign w_mask     = ~((NUM_REQ'(1) << r_ptr) - NUM_REQ'(1));
  assign w_masked   = req & w_mask;
  assign w_pick_src = (|w_masked) ? w_masked : req;
  assign grant      = w_pick_src & (~w_pick_src + NUM_REQ'(1));

  always_comb begin
    w_winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        w_winner = c_PTR_W'(i);
      end
    end
  end

  assign w_ptr_nxt = (w_winner == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + c_PTR_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register-file write port among write-back sources
//               and tracks destinations with outstanding writes for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = regfile_pkg::ADDR_W,
  parameter int DATA_W  = regfile_pkg::DATA_W
) (
  input  wire                     clock,
  input  wire                     reset_n,
  regfile_write_arbiter_if.slave  req,
  input  wire                     issue_valid,
  input  wire        [ADDR_W-1:0] issue_reg,
  input  wire        [ADDR_W-1:0] rs,
  input  wire        [ADDR_W-1:0] rt,
  output logic                    rs_busy,
  output logic                    rt_busy,
  output logic       [ADDR_W-1:0] write_reg,
  output logic       [DATA_W-1:0] write_data,
  output logic                    write_enable
);

  import regfile_pkg::*;

  localparam int c_NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] c_ZERO = ADDR_W'(ZERO_REG);

  logic [NUM_REQ-1:0]    w_grant_raw;
  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_handshake;
  logic [ADDR_W-1:0]     w_win_reg;
  logic [DATA_W-1:0]     w_win_data;
  logic [ADDR_W-1:0]     r_write_reg;
  logic [DATA_W-1:0]     r_write_data;
  logic                  r_write_enable;
  logic [c_NUM_REGS-1:0] r_busy;
  logic [c_NUM_REGS-1:0] w_busy_nxt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req.req_valid),
    .advance (w_handshake),
    .grant   (w_grant_raw)
  );

  // No grants may escape while reset is held, even with requests pending.
  assign w_grant       = w_grant_raw & {NUM_REQ{reset_n}};
  assign w_handshake   = |w_grant;
  assign req.req_ready = w_grant;

  always_comb begin
    w_win_reg  = '0;
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_win_reg  = req.req_reg[i*ADDR_W +: ADDR_W];
        w_win_data = req.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to r0 are accepted from the requester but never reach the file.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_write_reg    <= '0;
      r_write_data   <= '0;
      r_write_enable <= 1'b0;
    end else begin
      r_write_enable <= w_handshake && (w_win_reg != c_ZERO);
      if (w_handshake) begin
        r_write_reg  <= w_win_reg;
        r_write_data <= w_win_data;
      end
    end
  end

  // Set is applied after clear so a fresh producer outranks the retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_write_enable) begin
      w_busy_nxt[r_write_reg] = 1'b0;
    end
    if (issue_valid && (issue_reg != c_ZERO)) begin
      w_busy_nxt[issue_reg] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign rs_busy      = r_busy[rs];
  assign rt_busy      = r_busy[rt];
  assign write_reg    = r_write_reg;
  assign write_data   = r_write_data;
  assign write_enable = r_write_enable;

endmodule
`default_nettype wire
